mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one slow_memory port between the I-cache and D-cache miss/write-back
//  interfaces inside CHIP, for configurations with one external memory (L2 path).
//  Accepts line-sized (128b) read/write requests from both caches and serializes
//  them onto the memory handshake. Returns read data and a one-cycle ready pulse
//  to the granted cache only.
// PARAMETERS
//  ADDR_W      28   line address width (byte address bits [31:4])
//  LINE_W      128  line data width
//  D_PRIORITY  0    1: D-cache always wins a tie; 0: round-robin on tie
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous active-low reset
//  d_read     in   1       D-cache line read request; held until d_ready
//  d_write    in   1       D-cache line write request; held until d_ready
//  d_addr     in   ADDR_W  D-cache line address
//  d_wdata    in   LINE_W  D-cache write line
//  d_rdata    out  LINE_W  D-cache read line; valid while d_ready=1
//  d_ready    out  1       one-cycle completion pulse to D-cache
//  i_read/i_write/i_addr/i_wdata/i_rdata/i_ready   same as d_*, for I-cache
//  mem_read   out  1       to slow memory; held until mem_ready
//  mem_write  out  1       to slow memory; held until mem_ready
//  mem_addr   out  ADDR_W  latched line address
//  mem_wdata  out  LINE_W  latched write line
//  mem_rdata  in   LINE_W  read line from memory, valid with mem_ready
//  mem_ready  in   1       memory completion pulse
//  busy       out  1       high in any state except IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE; mem_read, mem_write, d_ready,
//    i_ready, busy = 0; mem_addr, mem_wdata, d_rdata, i_rdata = 0; last_grant=I.
//  - FSM: IDLE -> ACCESS -> DONE -> IDLE.
//  - IDLE: if a request is present, pick winner, latch op/addr/wdata, go ACCESS;
//    mem_read/mem_write rise the cycle after the request is first sampled.
//  - Tie (both ports requesting in the same IDLE cycle): D_PRIORITY=1 -> D;
//    else grant the port not in last_grant. last_grant updates on grant.
//  - Same port asserting read and write together: illegal; write takes effect.
//  - ACCESS: hold mem_* stable; ignore all cache inputs (changes do not alter the
//    latched request). On mem_ready: capture mem_rdata into winner's rdata
//    (read ops only), deassert mem_read/mem_write, go DONE.
//  - DONE: winner's ready=1 for exactly this cycle, mem_* request low; go IDLE.
//    Loser's request stays pending, granted from the next IDLE.
//  - Minimum turnaround: request sampled cycle t -> mem request t+1 -> mem_ready
//    at t+k -> cache ready at t+k+1 -> next grant sampled at t+k+2.
//  - x_rdata holds its last read line until the next read completes for that
//    port; a completed write does not modify it.
//  - Starvation bound (D_PRIORITY=0): a pending port waits at most one
//    transaction of the other port.
//  - mem_ready outside ACCESS is ignored.
//  - Reset asserted mid-transaction: return to reset values immediately;
//    the in-flight memory request is dropped, with no ready pulse to either cache.
// STRUCTURE
//  - Shared package mem_arb_pkg: ADDR_W/LINE_W constants, state encoding
//    (IDLE, ACCESS, DONE), and grant encoding (GNT_D, GNT_I).
//  - One sub-module rr_arbiter2: a combinational 2-way grant from (req_d, req_i,
//    last_grant, D_PRIORITY). FSM, latches, and data path stay in mem_arbiter.
// TESTING (slow_memory model as the memory side)
//  1 D read only, addr 28'h0000010 -> single mem_read with mem_addr=28'h10;
//    d_rdata=mem line at d_ready; i_ready never pulses.
//  2 I read 28'h0000004 and D write 28'h0000020 (wdata 128'hA5..A5) raised the
//    same cycle, D_PRIORITY=0, last_grant=I -> D served first; memory line
//    0x20=A5..A5; then I served; i_rdata correct; exactly 2 ready pulses total.
//  3 D_PRIORITY=1, both ports requesting continuously for 4 transactions -> all
//    go to D; with D_PRIORITY=0 the grants alternate D,I,D,I.
//  4 I read completes (i_rdata=X), then D write completes -> i_rdata still X,
//    d_rdata unchanged.
//  5 d_addr changed during ACCESS -> mem_addr stays at the latched value until
//    mem_ready.
//  6 rst_n low for 1 cycle mid-ACCESS -> mem_read drops immediately, busy=0,
//    no ready pulse; a fresh request after reset completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and encodings for the two-cache memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_D = 1'b0,
    GNT_I = 1'b1
  } gnt_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant between D-cache and I-cache requests: fixed D priority or round-robin on tie.
// Latency: combinational.
// Backpressure: none; the caller samples the grant only when it can start a transaction.
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter bit D_PRIORITY = 1'b0
) (
  input  logic req_d,
  input  logic req_i,
  input  gnt_t last_grant,
  output gnt_t gnt,
  output logic gnt_vld
);

  always_comb begin
    gnt = GNT_D;
    if (req_d && req_i) begin
      // On a tie the port that did not win last time goes first.
      if (!D_PRIORITY && last_grant == GNT_D) begin
        gnt = GNT_I;
      end
    end else if (req_i) begin
      gnt = GNT_I;
    end
  end

  assign gnt_vld = req_d | req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Serializes I-cache and D-cache line requests onto one slow memory port.
// Latency: request sampled t -> mem request t+1; mem_ready at t+k -> cache ready at t+k+1.
// Backpressure: requests are held by the caches until their one-cycle ready; the loser waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = mem_arb_pkg::ADDR_W,
  parameter int LINE_W     = mem_arb_pkg::LINE_W,
  parameter bit D_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  state_t state;
  gnt_t   gnt;
  gnt_t   last_grant;
  gnt_t   owner;
  logic   gnt_vld;
  req_t   d_req;
  req_t   i_req;
  req_t   win_req;

  // A port asserting read and write together is treated as a write.
  assign d_req   = '{wr: d_write, addr: d_addr, wdata: d_wdata};
  assign i_req   = '{wr: i_write, addr: i_addr, wdata: i_wdata};
  assign win_req = (gnt == GNT_D) ? d_req : i_req;

  rr_arbiter2 #(
    .D_PRIORITY(D_PRIORITY)
  ) u_rr_arbiter2 (
    .req_d     (d_read | d_write),
    .req_i     (i_read | i_write),
    .last_grant(last_grant),
    .gnt       (gnt),
    .gnt_vld   (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_I;
      owner      <= GNT_D;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      d_rdata    <= '0;
      i_rdata    <= '0;
      d_ready    <= 1'b0;
      i_ready    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          d_ready <= 1'b0;
          i_ready <= 1'b0;
          if (gnt_vld) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            owner      <= gnt;
            last_grant <= gnt;
            mem_read   <= ~win_req.wr;
            mem_write  <= win_req.wr;
            mem_addr   <= win_req.addr;
            mem_wdata  <= win_req.wdata;
          end
        end
        ACCESS: begin
          // Cache inputs are ignored here; only the latched request drives memory.
          if (mem_ready) begin
            state     <= DONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (owner == GNT_D) begin
              d_ready <= 1'b1;
              if (mem_read) d_rdata <= mem_rdata;
            end else begin
              i_ready <= 1'b1;
              if (mem_read) i_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          d_ready <= 1'b0;
          i_ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin and D-priority) behind a slow memory model.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          d_read_r [2];
  logic          d_write_r[2];
  logic [AW-1:0] d_addr_r [2];
  logic [LW-1:0] d_wdata_r[2];
  logic          i_read_r [2];
  logic          i_write_r[2];
  logic [AW-1:0] i_addr_r [2];
  logic [LW-1:0] i_wdata_r[2];
  logic [LW-1:0] d_rdata_w[2];
  logic [LW-1:0] i_rdata_w[2];
  logic          d_ready_w[2];
  logic          i_ready_w[2];
  logic          mem_read_w [2];
  logic          mem_write_w[2];
  logic [AW-1:0] mem_addr_w [2];
  logic [LW-1:0] mem_wdata_w[2];
  logic          busy_w[2];
  logic          stray[2];
  logic          hold_mem[2];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            model_last[2];
  logic [LW-1:0] ref_mem[2][64];
  logic [LW-1:0] ref_drd[2];
  logic [LW-1:0] ref_ird[2];
  txn_t          dq[$];
  txn_t          iq[$];
  bit            order[$];
  int            ready_cnt;

  function automatic logic [LW-1:0] init_line(input int g, input int a);
    return {32'(a) * 32'h9E3779B1, 32'(g + 1) * 32'h01000193, ~32'(a), 32'(a) ^ 32'h5A5A5A5A};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    logic          mem_ready_q;
    logic          mem_ready_in;
    logic [LW-1:0] mem_rdata_q;
    logic [LW-1:0] mem_arr[64];
    bit            init_done;
    int            cnt;
    int            lat;

    assign mem_ready_in = mem_ready_q | stray[g];

    mem_arbiter #(
      .ADDR_W    (AW),
      .LINE_W    (LW),
      .D_PRIORITY(g == 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .d_read   (d_read_r[g]),
      .d_write  (d_write_r[g]),
      .d_addr   (d_addr_r[g]),
      .d_wdata  (d_wdata_r[g]),
      .d_rdata  (d_rdata_w[g]),
      .d_ready  (d_ready_w[g]),
      .i_read   (i_read_r[g]),
      .i_write  (i_write_r[g]),
      .i_addr   (i_addr_r[g]),
      .i_wdata  (i_wdata_r[g]),
      .i_rdata  (i_rdata_w[g]),
      .i_ready  (i_ready_w[g]),
      .mem_read (mem_read_w[g]),
      .mem_write(mem_write_w[g]),
      .mem_addr (mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]),
      .mem_rdata(mem_rdata_q),
      .mem_ready(mem_ready_in),
      .busy     (busy_w[g])
    );

    // Slow memory: random 1..4 cycle latency, garbage on rdata outside the ready pulse.
    always @(posedge clk) begin
      if (!init_done) begin
        for (int a = 0; a < 64; a++) mem_arr[a] <= init_line(g, a);
        init_done <= 1'b1;
      end
      if (!rst_n) begin
        mem_ready_q <= 1'b0;
        mem_rdata_q <= '0;
        cnt         <= 0;
        lat         <= 1;
      end else begin
        mem_ready_q <= 1'b0;
        mem_rdata_q <= {$urandom, $urandom, $urandom, $urandom};
        if ((mem_read_w[g] || mem_write_w[g]) && !mem_ready_q && !hold_mem[g]) begin
          if (cnt >= lat) begin
            mem_ready_q <= 1'b1;
            cnt         <= 0;
            lat         <= $urandom_range(0, 3);
            if (mem_write_w[g]) mem_arr[mem_addr_w[g][5:0]] <= mem_wdata_w[g];
            else mem_rdata_q <= mem_arr[mem_addr_w[g][5:0]];
          end else begin
            cnt <= cnt + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Winner per the arbitration rule: a lone requester wins; ties go to D under
  // D priority, otherwise to the port that did not win last.
  function automatic int pick(input int g, input bit dp, input bit ip);
    if (dp && ip) return (g == 1) ? 0 : ((model_last[g] == 1) ? 0 : 1);
    return dp ? 0 : 1;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    int   op;
    op      = $urandom_range(1, 3);
    t.rd    = op[0];
    t.wr    = op[1];
    t.addr  = AW'($urandom_range(0, 63));
    t.wdata = {$urandom, $urandom, $urandom, $urandom};
    return t;
  endfunction

  function automatic txn_t mk(input bit rd, input bit wr, input int a, input logic [LW-1:0] wd);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = AW'(a); t.wdata = wd;
    return t;
  endfunction

  task automatic drive_d(input int g, input bit act, input txn_t t);
    d_read_r[g]  = act & t.rd;
    d_write_r[g] = act & t.wr;
    if (act) begin
      d_addr_r[g]  = t.addr;
      d_wdata_r[g] = t.wdata;
    end
  endtask

  task automatic drive_i(input int g, input bit act, input txn_t t);
    i_read_r[g]  = act & t.rd;
    i_write_r[g] = act & t.wr;
    if (act) begin
      i_addr_r[g]  = t.addr;
      i_wdata_r[g] = t.wdata;
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < 2; g++) begin
      model_last[g] = 1;
      ref_drd[g]    = '0;
      ref_ird[g]    = '0;
    end
  endtask

  // Presents dq/iq back-to-back on instance g and checks every grant and completion.
  task automatic run(input int g);
    txn_t dcur, icur, cur;
    bit   dact, iact, wv, prev_req, req_now;
    int   w;
    order.delete();
    ready_cnt = 0;
    w = 0; wv = 0; prev_req = 0;
    dcur = '0; icur = '0; cur = '0;
    dact = (dq.size() > 0);
    iact = (iq.size() > 0);
    if (dact) dcur = dq.pop_front();
    if (iact) icur = iq.pop_front();
    drive_d(g, dact, dcur);
    drive_i(g, iact, icur);
    for (int cyc = 0; cyc < 500 && (dact || iact || wv); cyc++) begin
      @(negedge clk);
      req_now = mem_read_w[g] | mem_write_w[g];
      if (req_now && !prev_req) begin
        chk("grant_while_pending", LW'(wv), '0);
        chk("grant_has_requester", LW'(dact | iact), 1);
        w = pick(g, dact, iact);
        model_last[g] = w;
        wv  = 1;
        cur = (w == 0) ? dcur : icur;
        chk("mem_op", {mem_write_w[g], mem_read_w[g]}, cur.wr ? 2'b10 : 2'b01);
        // Disturb the winner's inputs; the latched request must not follow them.
        if (w == 0) begin
          d_addr_r[g]  = AW'($urandom);
          d_wdata_r[g] = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          i_addr_r[g]  = AW'($urandom);
          i_wdata_r[g] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (req_now && wv) begin
        chk("mem_addr", mem_addr_w[g], cur.addr);
        if (cur.wr) chk("mem_wdata", mem_wdata_w[g], cur.wdata);
        chk("busy_access", busy_w[g], 1);
      end
      prev_req = req_now;
      if (d_ready_w[g] || i_ready_w[g]) begin
        chk("ready_owner", {i_ready_w[g], d_ready_w[g]}, !wv ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10));
        if (wv) begin
          if (cur.wr) ref_mem[g][cur.addr[5:0]] = cur.wdata;
          else if (w == 0) ref_drd[g] = ref_mem[g][cur.addr[5:0]];
          else ref_ird[g] = ref_mem[g][cur.addr[5:0]];
          chk("d_rdata", d_rdata_w[g], ref_drd[g]);
          chk("i_rdata", i_rdata_w[g], ref_ird[g]);
          ready_cnt++;
          order.push_back(w == 1);
          wv = 0;
          if (w == 0) begin
            dact = (dq.size() > 0);
            if (dact) dcur = dq.pop_front();
            drive_d(g, dact, dcur);
          end else begin
            iact = (iq.size() > 0);
            if (iact) icur = iq.pop_front();
            drive_i(g, iact, icur);
          end
        end
      end
    end
    chk("run_timeout", LW'(dact | iact | wv), '0);
    @(negedge clk);
    chk("idle_after", {busy_w[g], d_ready_w[g], i_ready_w[g]}, 3'b000);
  endtask

  initial begin
    txn_t          t;
    bit            found;
    logic [LW-1:0] exp_line, exp_d;

    for (int g = 0; g < 2; g++) begin
      for (int a = 0; a < 64; a++) ref_mem[g][a] = init_line(g, a);
      drive_d(g, 0, '0);
      drive_i(g, 0, '0);
      d_addr_r[g] = '0; d_wdata_r[g] = '0;
      i_addr_r[g] = '0; i_wdata_r[g] = '0;
      stray[g] = 1'b0;
      hold_mem[g] = 1'b0;
    end
    model_reset();

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_busy", busy_w[g], 0);
      chk("rst_mem_rw", {mem_read_w[g], mem_write_w[g]}, 2'b00);
      chk("rst_ready", {d_ready_w[g], i_ready_w[g]}, 2'b00);
      chk("rst_mem_addr", mem_addr_w[g], 0);
      chk("rst_mem_wdata", mem_wdata_w[g], 0);
      chk("rst_d_rdata", d_rdata_w[g], 0);
      chk("rst_i_rdata", i_rdata_w[g], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // D read alone
    dq.push_back(mk(1, 0, 'h10, '0));
    run(0);
    chk("t1_ready_cnt", ready_cnt, 1);
    chk("t1_port", LW'(order[0]), 0);

    // Idle reset pulse so last_grant is I again
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    // Simultaneous D write / I read: D first, then I
    dq.push_back(mk(0, 1, 'h20, {16{8'hA5}}));
    iq.push_back(mk(1, 0, 'h04, '0));
    run(0);
    chk("t2_ready_cnt", ready_cnt, 2);
    chk("t2_order", LW'({order[0], order[1]}), 2'b01);
    chk("t2_mem_line", gen_dut[0].mem_arr[32], {16{8'hA5}});

    // Continuous requests: alternate under round-robin, all D under D priority
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 4; k++) begin
        dq.push_back(mk(1, 0, $urandom_range(0, 63), '0));
        iq.push_back(mk(1, 0, $urandom_range(0, 63), '0));
      end
      run(g);
      chk("t3_order", LW'({order[0], order[1], order[2], order[3]}), (g == 1) ? 4'b0000 : 4'b0101);
    end

    // A D write does not disturb i_rdata or d_rdata
    exp_line = ref_mem[0][9];
    iq.push_back(mk(1, 0, 9, '0));
    run(0);
    chk("t4_i_read", i_rdata_w[0], exp_line);
    exp_d = ref_drd[0];
    dq.push_back(mk(0, 1, 9, {$urandom, $urandom, $urandom, $urandom}));
    run(0);
    chk("t4_i_hold", i_rdata_w[0], exp_line);
    chk("t4_d_hold", d_rdata_w[0], exp_d);

    // Reset in the middle of an access
    hold_mem[0] = 1'b1;
    t = mk(1, 0, 'h11, '0);
    drive_d(0, 1, t);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = mem_read_w[0];
    end
    chk("t6_reached_access", LW'(found), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_mem_read", mem_read_w[0], 0);
    chk("t6_busy", busy_w[0], 0);
    chk("t6_mem_addr", mem_addr_w[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_d(0, 0, t);
    hold_mem[0] = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_quiet", {d_ready_w[0], i_ready_w[0], busy_w[0], mem_read_w[0]}, 4'b0000);
    end
    dq.push_back(t);
    run(0);
    chk("t6_fresh_cnt", ready_cnt, 1);

    // Stray mem_ready while idle
    stray[0] = 1'b1;
    @(negedge clk);
    stray[0] = 1'b0;
    chk("stray_state", {busy_w[0], d_ready_w[0], i_ready_w[0]}, 3'b000);
    @(negedge clk);
    chk("stray_ready", {d_ready_w[0], i_ready_w[0]}, 2'b00);
    chk("stray_d_rdata", d_rdata_w[0], ref_drd[0]);
    chk("stray_i_rdata", i_rdata_w[0], ref_ird[0]);

    // Randomized traffic on both instances
    for (int r = 0; r < 30; r++) begin
      int nd, ni;
      nd = $urandom_range(0, 3);
      ni = $urandom_range((nd == 0) ? 1 : 0, 3);
      for (int k = 0; k < nd; k++) dq.push_back(rand_txn());
      for (int k = 0; k < ni; k++) iq.push_back(rand_txn());
      run(r % 2);
      chk("rand_ready_cnt", ready_cnt, nd + ni);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
